// File: rtl/hdmi_val_scheduler_if.sv
// hdmi_val_scheduler_if: sample-stream bundle around the scheduler.
// Carries the two acquisition channels (valid/ready/data) and the
// val/readValEn word stream toward hdmiIP. The scheduler uses the slave
// modport. The sample sources and the display sink use the master modport.
interface hdmi_val_scheduler_if #(
  parameter int VAL_RES = 12
);
  logic               a_valid;
  logic [VAL_RES-1:0] a_data;
  logic               a_ready;
  logic               b_valid;
  logic [VAL_RES-1:0] b_data;
  logic               b_ready;
  logic [VAL_RES-1:0] val;
  logic               readValEn;

  modport slave (
    input  a_valid, a_data, b_valid, b_data,
    output a_ready, b_ready, val, readValEn
  );

  modport master (
    output a_valid, a_data, b_valid, b_data,
    input  a_ready, b_ready, val, readValEn
  );
endinterface

// File: rtl/hdmi_val_scheduler.sv
// hdmi_val_scheduler: round-robin merge of acquisition channels A/B into
// the hdmiIP val stream. Each frame carries exactly `width` words.
// Geometry is shadowed and changes only at frame boundaries. On starvation,
// zero pad words are inserted so that the frame length stays fixed.
// Optional feature macro: HDMI_SCHED_TRIGGER_EN adds an ARM state. In ARM,
// the scheduler waits for a rising crossing of trig_level on channel A
// before it starts to fill the frame.
module hdmi_val_scheduler #(
  parameter int VAL_RES = 12,
  parameter int DIM_W   = 32,
  parameter int TIMEOUT = 64,
  parameter int MAX_DIM = 640
) (
  input  logic               pixclk,
  input  logic               rst_n,
  input  logic               frame_start,
  hdmi_val_scheduler_if.slave bus,
  input  logic               cfg_we,
  input  logic [DIM_W-1:0]   cfg_width,
  input  logic [DIM_W-1:0]   cfg_height,
  input  logic [VAL_RES-1:0] trig_level,
  output logic [DIM_W-1:0]   width,
  output logic [DIM_W-1:0]   height,
  output logic               busy,
  output logic               underrun,
  output logic [15:0]        pad_cnt
);

  localparam int                TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]     TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [DIM_W-1:0]  RST_W    = DIM_W'(640);
  localparam logic [DIM_W-1:0]  RST_H    = DIM_W'(480);
  localparam logic [DIM_W-1:0]  DIM_MAX  = DIM_W'(MAX_DIM);

`ifdef HDMI_SCHED_TRIGGER_EN
  typedef enum logic [1:0] {S_IDLE, S_ARM, S_FILL, S_DONE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;
`endif

  typedef enum logic {CH_A, CH_B} chan_t;

  state_t             state_q,   state_d;
  logic [VAL_RES-1:0] val_q,     val_d;
  logic               rven_q,    rven_d;
  logic [DIM_W-1:0]   width_q,   width_d;
  logic [DIM_W-1:0]   height_q,  height_d;
  logic [DIM_W-1:0]   pend_w_q,  pend_w_d;
  logic [DIM_W-1:0]   pend_h_q,  pend_h_d;
  logic [DIM_W-1:0]   col_q,     col_d;
  logic [TW-1:0]      timer_q,   timer_d;
  chan_t              rr_q,      rr_d;
  logic               under_q,   under_d;
  logic [15:0]        pad_q,     pad_d;

  logic               a_rdy, b_rdy, a_xfer, b_xfer, word;

`ifdef HDMI_SCHED_TRIGGER_EN
  logic [VAL_RES-1:0] prev_q, prev_d;
  logic               prev_vld_q, prev_vld_d;
`else
  // The trigger threshold only matters when the ARM state is built in.
  logic               unused_trig;
  assign unused_trig = ^trig_level;
`endif

  assign a_xfer = a_rdy && bus.a_valid;
  assign b_xfer = b_rdy && bus.b_valid;

  // Next-state, grant, word-issue and configuration logic.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves it unassigned and no latch is inferred.
    state_d  = state_q;
    val_d    = val_q;
    rven_d   = 1'b0;
    width_d  = width_q;
    height_d = height_q;
    pend_w_d = pend_w_q;
    pend_h_d = pend_h_q;
    col_d    = col_q;
    timer_d  = timer_q;
    rr_d     = rr_q;
    under_d  = under_q;
    pad_d    = pad_q;
    a_rdy    = 1'b0;
    b_rdy    = 1'b0;
    word     = 1'b0;
`ifdef HDMI_SCHED_TRIGGER_EN
    prev_d     = prev_q;
    prev_vld_d = prev_vld_q;
`endif

    // An illegal width rejects the whole write, so geometry stays consistent.
    if (cfg_we && (cfg_width != '0) && (cfg_width <= DIM_MAX)) begin
      pend_w_d = cfg_width;
      pend_h_d = cfg_height;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (frame_start) begin
          width_d  = pend_w_q;
          height_d = pend_h_q;
          col_d    = '0;
          pad_d    = '0;
          timer_d  = '0;
`ifdef HDMI_SCHED_TRIGGER_EN
          prev_vld_d = 1'b0;
          state_d    = S_ARM;
`else
          state_d    = S_FILL;
`endif
        end
      end

`ifdef HDMI_SCHED_TRIGGER_EN
      S_ARM: begin
        // Channel A is drained while the scheduler looks for a rising crossing.
        // A frame_start in this state leaves the scheduler in ARM.
        a_rdy = 1'b1;
        if (bus.a_valid) begin
          prev_d     = bus.a_data;
          prev_vld_d = 1'b1;
          if (prev_vld_q && (prev_q < trig_level) && (trig_level <= bus.a_data)) begin
            val_d   = bus.a_data;
            rven_d  = 1'b1;
            rr_d    = CH_B;
            timer_d = '0;
            if (width_q == DIM_W'(1)) begin
              col_d   = '0;
              state_d = S_DONE;
            end else begin
              col_d   = DIM_W'(1);
              state_d = S_FILL;
            end
          end
        end
      end
`endif

      S_FILL: begin
        // The round-robin holder wins a tie. A lone valid channel is granted every cycle.
        a_rdy = bus.a_valid && ((rr_q == CH_A) || !bus.b_valid);
        b_rdy = bus.b_valid && ((rr_q == CH_B) || !bus.a_valid);
        if (a_xfer || b_xfer) begin
          val_d   = a_xfer ? bus.a_data : bus.b_data;
          rven_d  = 1'b1;
          rr_d    = a_xfer ? CH_B : CH_A;
          timer_d = '0;
          word    = 1'b1;
        end else if (timer_q == TMO_LAST) begin
          val_d   = '0;
          rven_d  = 1'b1;
          timer_d = '0;
          word    = 1'b1;
          if (pad_q != 16'hFFFF) pad_d = pad_q + 16'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end

        if (frame_start) begin
          // hdmiIP has already started the next frame, so the short frame is abandoned.
          under_d = 1'b1;
          col_d   = '0;
          pad_d   = '0;
          timer_d = '0;
        end else if (word) begin
          if (col_q == width_q - DIM_W'(1)) begin
            col_d   = '0;
            state_d = S_DONE;
          end else begin
            col_d = col_q + DIM_W'(1);
          end
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge pixclk) begin
    // NOTE: registers take non-blocking assignments so that every flop samples pre-edge values.
    if (!rst_n) begin
      state_q  <= S_IDLE;
      val_q    <= '0;
      rven_q   <= 1'b0;
      width_q  <= RST_W;
      height_q <= RST_H;
      pend_w_q <= RST_W;
      pend_h_q <= RST_H;
      col_q    <= '0;
      timer_q  <= '0;
      rr_q     <= CH_A;
      under_q  <= 1'b0;
      pad_q    <= '0;
`ifdef HDMI_SCHED_TRIGGER_EN
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      val_q    <= val_d;
      rven_q   <= rven_d;
      width_q  <= width_d;
      height_q <= height_d;
      pend_w_q <= pend_w_d;
      pend_h_q <= pend_h_d;
      col_q    <= col_d;
      timer_q  <= timer_d;
      rr_q     <= rr_d;
      under_q  <= under_d;
      pad_q    <= pad_d;
`ifdef HDMI_SCHED_TRIGGER_EN
      prev_q     <= prev_d;
      prev_vld_q <= prev_vld_d;
`endif
    end
  end

  assign bus.a_ready   = a_rdy;
  assign bus.b_ready   = b_rdy;
  assign bus.val       = val_q;
  assign bus.readValEn = rven_q;
  assign width         = width_q;
  assign height        = height_q;
  assign underrun      = under_q;
  assign pad_cnt       = pad_q;
`ifdef HDMI_SCHED_TRIGGER_EN
  assign busy = (state_q == S_FILL) || (state_q == S_ARM);
`else
  assign busy = (state_q == S_FILL);
`endif

endmodule

// File: tb/tb_hdmi_val_scheduler.sv
// tb_hdmi_val_scheduler: directed self-checking bench for hdmi_val_scheduler.
// The default build is exercised. The trigger scenario is compiled only
// when HDMI_SCHED_TRIGGER_EN is defined.
module tb_hdmi_val_scheduler;

  localparam int VAL_RES = 12;
  localparam int DIM_W   = 32;
  localparam int TIMEOUT = 64;

  logic               pixclk = 1'b0;
  logic               rst_n;
  logic               frame_start;
  logic               cfg_we;
  logic [DIM_W-1:0]   cfg_width;
  logic [DIM_W-1:0]   cfg_height;
  logic [VAL_RES-1:0] trig_level;
  logic [DIM_W-1:0]   width;
  logic [DIM_W-1:0]   height;
  logic               busy;
  logic               underrun;
  logic [15:0]        pad_cnt;

  hdmi_val_scheduler_if #(.VAL_RES(VAL_RES)) bus_if ();

  hdmi_val_scheduler #(
    .VAL_RES(VAL_RES), .DIM_W(DIM_W), .TIMEOUT(TIMEOUT), .MAX_DIM(640)
  ) dut (
    .pixclk      (pixclk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .bus         (bus_if),
    .cfg_we      (cfg_we),
    .cfg_width   (cfg_width),
    .cfg_height  (cfg_height),
    .trig_level  (trig_level),
    .width       (width),
    .height      (height),
    .busy        (busy),
    .underrun    (underrun),
    .pad_cnt     (pad_cnt)
  );

  always #5 pixclk = ~pixclk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  logic [VAL_RES-1:0] sq[$];
  int                 cq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  always @(posedge pixclk) cyc++;

  // Strobe recorder and ready-exclusivity watch, sampled on the falling edge.
  always @(negedge pixclk) begin
    if (bus_if.readValEn) begin
      sq.push_back(bus_if.val);
      cq.push_back(cyc);
    end
    if (rst_n && busy) check("ready_mutex", {31'd0, bus_if.a_ready & bus_if.b_ready}, 32'd0);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pixclk);
    #1;
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic write_cfg(input int w, input int h);
    cfg_we = 1'b1; cfg_width = DIM_W'(w); cfg_height = DIM_W'(h);
    tick(1);
    cfg_we = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (!busy) break;
      tick(1);
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int fs_cyc;
    int n_before;
    rst_n = 1'b0; frame_start = 1'b0; cfg_we = 1'b0;
    cfg_width = '0; cfg_height = '0; trig_level = 12'h800;
    bus_if.a_valid = 1'b1; bus_if.b_valid = 1'b1;
    bus_if.a_data = '0; bus_if.b_data = '0;
    tick(3);
    rst_n = 1'b1;

    // Reset state: ready must be low outside FILL even with both valids high.
    check("rst_val",   {20'd0, bus_if.val}, 32'd0);
    check("rst_rven",  {31'd0, bus_if.readValEn}, 32'd0);
    check("rst_width", width, 32'd640);
    check("rst_height", height, 32'd480);
    check("rst_ardy",  {31'd0, bus_if.a_ready}, 32'd0);
    check("rst_brdy",  {31'd0, bus_if.b_ready}, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_under", {31'd0, underrun}, 32'd0);
    check("rst_pad",   {16'd0, pad_cnt}, 32'd0);

    // Arbitration with both channels valid: A,B,A,B,... over 8 columns.
    write_cfg(8, 4);
    check("cfg_no_fs", width, 32'd640);
    sq.delete(); cq.delete();
    pulse_fs();
    check("t2_width",  width, 32'd8);
    check("t2_height", height, 32'd4);
    for (int k = 0; k < 8; k++) begin
      bus_if.a_data = 12'h100 + 12'(k / 2);
      bus_if.b_data = 12'h200 + 12'(k / 2);
      check("t2_ardy", {31'd0, bus_if.a_ready}, {31'd0, (k % 2) == 0});
      tick(1);
    end
    check("t2_done_busy", {31'd0, busy}, 32'd0);
    check("t2_done_ardy", {31'd0, bus_if.a_ready}, 32'd0);
    tick(2);
    check("t2_count", sq.size(), 32'd8);
    for (int k = 0; k < 8 && k < sq.size(); k++)
      check("t2_val", {20'd0, sq[k]}, (k % 2) == 0 ? 32'h100 + k / 2 : 32'h200 + k / 2);
    if (sq.size() == 8) check("t2_contig", cq[7] - cq[0], 32'd7);

    // A lone valid channel is granted every cycle with no bubble.
    bus_if.a_valid = 1'b0;
    sq.delete(); cq.delete();
    pulse_fs();
    for (int k = 0; k < 8; k++) begin
      bus_if.b_data = 12'h300 + 12'(k);
      check("t2b_brdy", {31'd0, bus_if.b_ready}, 32'd1);
      tick(1);
    end
    bus_if.b_valid = 1'b0;
    check("t2b_busy", {31'd0, busy}, 32'd0);
    tick(2);
    check("t2b_count", sq.size(), 32'd8);
    for (int k = 0; k < 8 && k < sq.size(); k++)
      check("t2b_val", {20'd0, sq[k]}, 32'h300 + k);

    // Starvation: four zero pad words spaced TIMEOUT cycles apart.
    write_cfg(4, 4);
    sq.delete(); cq.delete();
    pulse_fs();
    fs_cyc = cyc;
    wait_idle("t3_timeout", 400);
    tick(2);
    check("t3_count", sq.size(), 32'd4);
    check("t3_pad_cnt", {16'd0, pad_cnt}, 32'd4);
    check("t3_under", {31'd0, underrun}, 32'd0);
    if (sq.size() == 4) begin
      check("t3_first", cq[0] - fs_cyc, TIMEOUT);
      for (int k = 0; k < 4; k++) check("t3_val", {20'd0, sq[k]}, 32'd0);
      for (int k = 1; k < 4; k++) check("t3_space", cq[k] - cq[k-1], TIMEOUT);
    end

    // Geometry shadowing: writes in FILL wait for the next frame, illegal widths are dropped.
    pulse_fs();
    check("t4_pad_clr", {16'd0, pad_cnt}, 32'd0);
    write_cfg(320, 4);
    check("t4_hold", width, 32'd4);
    write_cfg(0, 4);
    write_cfg(641, 4);
    check("t4_hold2", width, 32'd4);
    bus_if.a_valid = 1'b1;
    wait_idle("t4_fill4", 10);
    pulse_fs();
    check("t4_width", width, 32'd320);
    wait_idle("t4_fill320", 400);
    bus_if.a_valid = 1'b0;

    // Underrun: frame_start after 5 of 16 words restarts the column count.
    write_cfg(16, 8);
    pulse_fs();
    sq.delete(); cq.delete();
    bus_if.a_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      bus_if.a_data = 12'h400 + 12'(k);
      tick(1);
    end
    bus_if.a_valid = 1'b0;
    check("t5_under_pre", {31'd0, underrun}, 32'd0);
    pulse_fs();
    check("t5_under", {31'd0, underrun}, 32'd1);
    check("t5_busy", {31'd0, busy}, 32'd1);
    bus_if.a_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus_if.a_data = 12'h500 + 12'(k);
      if (k == 15) check("t5_busy15", {31'd0, busy}, 32'd1);
      tick(1);
    end
    check("t5_done", {31'd0, busy}, 32'd0);
    tick(2);
    check("t5_count", sq.size(), 32'd21);
    if (sq.size() == 21) begin
      check("t5_first_new", {20'd0, sq[5]}, 32'h500);
      check("t5_last_new", {20'd0, sq[20]}, 32'h50F);
    end
    check("t5_sticky", {31'd0, underrun}, 32'd1);

`ifdef HDMI_SCHED_TRIGGER_EN
    // Trigger: ARM drains A until the rising crossing of 0x800, which becomes column 0.
    write_cfg(4, 4);
    pulse_fs();
    sq.delete(); cq.delete();
    check("t6_arm_busy", {31'd0, busy}, 32'd1);
    for (int k = 0; k < 8; k++) begin
      bus_if.a_data = 12'h7F0 + 12'(8 * k);
      tick(1);
    end
    bus_if.a_valid = 1'b0;
    tick(2);
    check("t6_count", sq.size(), 32'd4);
    if (sq.size() == 4) begin
      check("t6_first", {20'd0, sq[0]}, 32'h800);
      check("t6_last",  {20'd0, sq[3]}, 32'h818);
    end
    bus_if.a_valid = 1'b1;
`endif

    // Reset mid-FILL aborts the frame and restores the defaults.
    pulse_fs();
    tick(3);
    rst_n = 1'b0;
    tick(1);
    n_before = sq.size();
    tick(2);
    check("t1_no_words", sq.size(), n_before);
    check("t1_val",    {20'd0, bus_if.val}, 32'd0);
    check("t1_rven",   {31'd0, bus_if.readValEn}, 32'd0);
    check("t1_width",  width, 32'd640);
    check("t1_height", height, 32'd480);
    check("t1_ardy",   {31'd0, bus_if.a_ready}, 32'd0);
    check("t1_brdy",   {31'd0, bus_if.b_ready}, 32'd0);
    check("t1_busy",   {31'd0, busy}, 32'd0);
    check("t1_under",  {31'd0, underrun}, 32'd0);
    rst_n = 1'b1;
    bus_if.a_valid = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
